// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub, one SEG-bit segment resolved per stage.
// Ports: CLK/RST, A/B/CIN/SUB + IN_VALID/IN_READY in; SUM/COUT/OVF/ZERO + OUT_VALID/OUT_READY out.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int NSTG = WIDTH / SEG;
  localparam int L    = NSTG - 1;

  if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of SEG");
  end

  // Slot k holds the operands and carry-in that stage k consumes,
  // plus the sum segments already resolved by stages 0..k-1.
  logic [NSTG-1:0]  vld_q, vld_d;
  logic [NSTG-1:0]  cin_q, cin_d;
  logic [WIDTH-1:0] opa_q [NSTG];
  logic [WIDTH-1:0] opa_d [NSTG];
  logic [WIDTH-1:0] opb_q [NSTG];
  logic [WIDTH-1:0] opb_d [NSTG];
  logic [WIDTH-1:0] part_q [NSTG];
  logic [WIDTH-1:0] part_d [NSTG];

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             stall;
  logic [SEG:0]     seg_r [NSTG];

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      seg_r[k] = {1'b0, opa_q[k][k*SEG +: SEG]}
               + {1'b0, opb_q[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, cin_q[k]};
    end
  end

  always_comb begin
    stall     = out_vld_q & ~OUT_READY;
    vld_d     = vld_q;
    cin_d     = cin_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    part_d    = part_q;
    out_vld_d = out_vld_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    if (!stall) begin
      vld_d[0]  = IN_VALID;
      part_d[0] = '0;
      if (IN_VALID) begin
        opa_d[0] = A;
        opb_d[0] = SUB ? ~B : B;
        cin_d[0] = SUB ^ CIN;
      end
      for (int k = 0; k < L; k++) begin
        vld_d[k+1] = vld_q[k];
        cin_d[k+1] = seg_r[k][SEG];
        opa_d[k+1] = opa_q[k];
        opb_d[k+1] = opb_q[k];
        part_d[k+1] = part_q[k];
        part_d[k+1][k*SEG +: SEG] = seg_r[k][SEG-1:0];
      end
      out_vld_d = vld_q[L];
      sum_d     = part_q[L];
      sum_d[L*SEG +: SEG] = seg_r[L][SEG-1:0];
      cout_d    = seg_r[L][SEG];
      // carry into the MSB is recovered from the MSB sum bit
      ovf_d     = seg_r[L][SEG]
                ^ opa_q[L][WIDTH-1]
                ^ opb_q[L][WIDTH-1]
                ^ seg_r[L][SEG-1];
      zero_d    = ~|sum_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q     <= '0;
      cin_q     <= '0;
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        opa_q[k]  <= '0;
        opb_q[k]  <= '0;
        part_q[k] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      cin_q     <= cin_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      part_q    <= part_d;
      out_vld_q <= out_vld_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign IN_READY  = ~stall;
  assign OUT_VALID = out_vld_q;
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule
